// File: rtl/time_set_ctrl.sv
// time_set_ctrl: run/set sequencer for the digital clock. It issues one-cycle
// inc/clr strobes and the mode/blink state. All outputs are registered.
//
// Ports:
//   selfClk, reset(async, active-low)
//   tick1hz, tick4hz            : one-cycle timing pulses
//   modeBtn, upBtn              : debounced synchronous button levels
//   secAtMax, minAtMax          : counter at-59 flags
//   secInc, minInc, hourInc     : one-cycle increment strobes
//   secClr                      : one-cycle seconds clear strobe
//   mode[1:0]                   : 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
//   blink                       : blink phase of the field being set
module time_set_ctrl #(
  parameter int unsigned TIMEOUT = 60
) (
  input  logic       selfClk,
  input  logic       reset,
  input  logic       tick1hz,
  input  logic       tick4hz,
  input  logic       modeBtn,
  input  logic       upBtn,
  input  logic       secAtMax,
  input  logic       minAtMax,
  output logic       secInc,
  output logic       minInc,
  output logic       hourInc,
  output logic       secClr,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_e;

  localparam logic [7:0] IdleLast = 8'(TIMEOUT - 1);

  mode_e      mode_q, mode_d;
  logic       blink_q, blink_d;
  logic [7:0] idle_q, idle_d;
  logic       rpt_q, rpt_d;
  logic       mprev_q, uprev_q;
  logic       sec_inc_q, sec_inc_d;
  logic       min_inc_q, min_inc_d;
  logic       hour_inc_q, hour_inc_d;
  logic       sec_clr_q, sec_clr_d;

  logic mode_edge, up_edge, adj_edge;
  logic in_set, timeout;

  assign mode_edge = modeBtn & ~mprev_q;
  assign up_edge   = upBtn & ~uprev_q;
  // A mode press in the same cycle swallows the adjust press.
  assign adj_edge  = up_edge & ~mode_edge;
  assign in_set    = (mode_q != RUN);
  assign timeout   = in_set & tick1hz & (idle_q == IdleLast);

  always_comb begin
    mode_d     = mode_q;
    blink_d    = blink_q;
    idle_d     = idle_q;
    // Auto-repeat stays armed only while the button is held.
    rpt_d      = rpt_q & upBtn;
    sec_inc_d  = 1'b0;
    min_inc_d  = 1'b0;
    hour_inc_d = 1'b0;
    sec_clr_d  = 1'b0;

    unique case (mode_q)
      RUN: begin
        if (tick1hz) begin
          sec_inc_d  = 1'b1;
          min_inc_d  = secAtMax;
          hour_inc_d = secAtMax & minAtMax;
        end
      end
      SET_HOUR: hour_inc_d = adj_edge | (rpt_q & upBtn & tick4hz);
      SET_MIN:  min_inc_d  = adj_edge | (rpt_q & upBtn & tick4hz);
      SET_SEC:  sec_clr_d  = adj_edge;
    endcase

    if (in_set && adj_edge) rpt_d = 1'b1;
    if (in_set && tick4hz) blink_d = ~blink_q;

    if (in_set && tick1hz) idle_d = idle_q + 8'd1;
    if (mode_edge || up_edge) idle_d = 8'd0;

    if (mode_edge) mode_d = mode_e'(mode_q + 2'd1);
    // Timeout outranks a mode press in the same cycle.
    if (timeout) begin
      mode_d = RUN;
      idle_d = 8'd0;
    end

    if (mode_d != mode_q) begin
      blink_d = 1'b0;
      rpt_d   = 1'b0;
      idle_d  = 8'd0;
    end
  end

  always_ff @(posedge selfClk or negedge reset) begin
    if (!reset) begin
      mode_q     <= RUN;
      blink_q    <= 1'b0;
      idle_q     <= 8'd0;
      rpt_q      <= 1'b0;
      // Held-through-reset buttons must not count as presses.
      mprev_q    <= 1'b1;
      uprev_q    <= 1'b1;
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      hour_inc_q <= 1'b0;
      sec_clr_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      blink_q    <= blink_d;
      idle_q     <= idle_d;
      rpt_q      <= rpt_d;
      mprev_q    <= modeBtn;
      uprev_q    <= upBtn;
      sec_inc_q  <= sec_inc_d;
      min_inc_q  <= min_inc_d;
      hour_inc_q <= hour_inc_d;
      sec_clr_q  <= sec_clr_d;
    end
  end

  assign secInc  = sec_inc_q;
  assign minInc  = min_inc_q;
  assign hourInc = hour_inc_q;
  assign secClr  = sec_clr_q;
  assign mode    = mode_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scenario bench for time_set_ctrl.
// Vectors: stim {modeBtn,upBtn,tick1hz,tick4hz,secAtMax,minAtMax}, out {secInc,minInc,hourInc,secClr,mode,blink}.
module tb_time_set_ctrl;

  logic       selfClk = 1'b0;
  logic       reset = 1'b0;
  logic       tick1hz = 1'b0;
  logic       tick4hz = 1'b0;
  logic       modeBtn = 1'b0;
  logic       upBtn = 1'b0;
  logic       secAtMax = 1'b0;
  logic       minAtMax = 1'b0;
  logic       secInc, minInc, hourInc, secClr;
  logic [1:0] mode;
  logic       blink;
  logic [6:0] obs;
  logic [6:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  assign obs = {secInc, minInc, hourInc, secClr, mode, blink};

  always #5 selfClk = ~selfClk;

  time_set_ctrl #(.TIMEOUT(60)) dut (
    .selfClk (selfClk),
    .reset   (reset),
    .tick1hz (tick1hz),
    .tick4hz (tick4hz),
    .modeBtn (modeBtn),
    .upBtn   (upBtn),
    .secAtMax(secAtMax),
    .minAtMax(minAtMax),
    .secInc  (secInc),
    .minInc  (minInc),
    .hourInc (hourInc),
    .secClr  (secClr),
    .mode    (mode),
    .blink   (blink)
  );

  task automatic drive(input logic [5:0] s);
    {modeBtn, upBtn, tick1hz, tick4hz, secAtMax, minAtMax} = s;
    @(posedge selfClk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(6'b000000);
    drive(6'b000000);
    reset = 1'b1;
    drive(6'b000000);
  endtask

  task automatic test_reset();
    logic [12:0] t[];
    logic [6:0]  e;
    reset = 1'b0;
    {modeBtn, upBtn} = 2'b11;
    @(posedge selfClk);
    #1;
    exp_q.push_back(7'b0000000);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", obs, e);
    end
    reset = 1'b1;
    t = '{
      {6'b110000, 7'b0000000},
      {6'b000000, 7'b0000000},
      {6'b110000, 7'b0000010},
      {6'b000000, 7'b0000010},
      {6'b110000, 7'b0000100},
      {6'b010000, 7'b0000100},
      {6'b010100, 7'b0000101}
    };
    foreach (t[i]) begin
      exp_q.push_back(t[i][6:0]);
      drive(t[i][12:7]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset_release step %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_run_carry();
    logic [12:0] t[];
    logic [6:0]  e;
    do_reset();
    t = '{
      {6'b001011, 7'b1110000},
      {6'b000011, 7'b0000000},
      {6'b001010, 7'b1100000},
      {6'b001001, 7'b1000000},
      {6'b001000, 7'b1000000},
      {6'b010000, 7'b0000000},
      {6'b000100, 7'b0000000},
      {6'b011111, 7'b1110000}
    };
    foreach (t[i]) begin
      exp_q.push_back(t[i][6:0]);
      drive(t[i][12:7]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL run_carry step %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_mode_cycle();
    logic [12:0] t[];
    logic [6:0]  e;
    do_reset();
    t = '{
      {6'b100000, 7'b0000010},
      {6'b000100, 7'b0000011},
      {6'b000100, 7'b0000010},
      {6'b000100, 7'b0000011},
      {6'b100000, 7'b0000100},
      {6'b000100, 7'b0000101},
      {6'b100100, 7'b0000110},
      {6'b000100, 7'b0000111},
      {6'b100000, 7'b0000000},
      {6'b000100, 7'b0000000},
      {6'b101100, 7'b1000010},
      {6'b000000, 7'b0000010}
    };
    foreach (t[i]) begin
      exp_q.push_back(t[i][6:0]);
      drive(t[i][12:7]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL mode_cycle step %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_set_min_repeat();
    logic [12:0] t[];
    logic [6:0]  e;
    int          n_min;
    do_reset();
    n_min = 0;
    t = '{
      {6'b100000, 7'b0000010},
      {6'b000000, 7'b0000010},
      {6'b100000, 7'b0000100},
      {6'b000000, 7'b0000100},
      {6'b010011, 7'b0100100},
      {6'b010011, 7'b0000100},
      {6'b010111, 7'b0100101},
      {6'b011011, 7'b0000101},
      {6'b010111, 7'b0100100},
      {6'b011111, 7'b0100101},
      {6'b010111, 7'b0100100},
      {6'b010111, 7'b0100101},
      {6'b000100, 7'b0000100},
      {6'b010100, 7'b0100101},
      {6'b000000, 7'b0000101}
    };
    foreach (t[i]) begin
      exp_q.push_back(t[i][6:0]);
      drive(t[i][12:7]);
      if (minInc === 1'b1) n_min++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL set_min step %0d: got %b want %b", i, obs, e);
      end
    end
    n_cmp++;
    if (n_min !== 7) begin
      n_bad++;
      $display("FAIL set_min_count: got %0d want 7", n_min);
    end
  endtask

  task automatic test_set_sec();
    logic [12:0] t[];
    logic [6:0]  e;
    do_reset();
    t = '{
      {6'b100000, 7'b0000010},
      {6'b000000, 7'b0000010},
      {6'b100000, 7'b0000100},
      {6'b000000, 7'b0000100},
      {6'b100000, 7'b0000110},
      {6'b000000, 7'b0000110},
      {6'b010000, 7'b0001110},
      {6'b011110, 7'b0000111},
      {6'b010110, 7'b0000110},
      {6'b011110, 7'b0000111},
      {6'b010110, 7'b0000110},
      {6'b011110, 7'b0000111},
      {6'b010110, 7'b0000110},
      {6'b011110, 7'b0000111},
      {6'b010110, 7'b0000110},
      {6'b000000, 7'b0000110},
      {6'b010000, 7'b0001110},
      {6'b000000, 7'b0000110}
    };
    foreach (t[i]) begin
      exp_q.push_back(t[i][6:0]);
      drive(t[i][12:7]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL set_sec step %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [12:0] q[$];
    logic [6:0]  x;
    logic [6:0]  e;
    logic [12:0] s;
    do_reset();
    // Round 1: untouched SET_HOUR returns to RUN on the 60th tick.
    q.push_back({6'b100000, 7'b0000010});
    q.push_back({6'b000000, 7'b0000010});
    q.push_back({6'b010000, 7'b0010010});
    q.push_back({6'b000000, 7'b0000010});
    for (int k = 1; k <= 60; k++) begin
      x = (k < 60) ? 7'b0000011 : 7'b0000000;
      q.push_back({(k == 1) ? 6'b001100 : 6'b001000, x});
      q.push_back({6'b000000, x});
    end
    // Round 2: a press after 30 ticks restarts the idle count.
    q.push_back({6'b100000, 7'b0000010});
    q.push_back({6'b000000, 7'b0000010});
    for (int k = 1; k <= 30; k++) begin
      q.push_back({6'b001000, 7'b0000010});
      q.push_back({6'b000000, 7'b0000010});
    end
    q.push_back({6'b010000, 7'b0010010});
    q.push_back({6'b000000, 7'b0000010});
    for (int k = 1; k <= 60; k++) begin
      x = (k < 60) ? 7'b0000010 : 7'b0000000;
      q.push_back({6'b001000, x});
      q.push_back({6'b000000, x});
    end
    // Round 3: mode press on the timeout tick still lands in RUN.
    q.push_back({6'b100000, 7'b0000010});
    q.push_back({6'b000000, 7'b0000010});
    for (int k = 1; k <= 59; k++) begin
      q.push_back({6'b001000, 7'b0000010});
      q.push_back({6'b000000, 7'b0000010});
    end
    q.push_back({6'b101000, 7'b0000000});
    q.push_back({6'b000000, 7'b0000000});
    foreach (q[i]) begin
      s = q[i];
      exp_q.push_back(s[6:0]);
      drive(s[12:7]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL timeout step %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] t[];
    logic [6:0]  e;
    do_reset();
    t = '{
      {6'b100000, 7'b0000010},
      {6'b000000, 7'b0000010},
      {6'b010000, 7'b0010010}
    };
    foreach (t[i]) begin
      exp_q.push_back(t[i][6:0]);
      drive(t[i][12:7]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset_mid_pre step %0d: got %b want %b", i, obs, e);
      end
    end
    reset = 1'b0;
    #1;
    exp_q.push_back(7'b0000000);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL reset_async: got %b want %b", obs, e);
    end
    drive(6'b010100);
    reset = 1'b1;
    t = '{
      {6'b010100, 7'b0000000},
      {6'b010100, 7'b0000000},
      {6'b000000, 7'b0000000},
      {6'b100000, 7'b0000010}
    };
    foreach (t[i]) begin
      exp_q.push_back(t[i][6:0]);
      drive(t[i][12:7]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset_mid_post step %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_carry();
    test_mode_cycle();
    test_set_min_repeat();
    test_set_sec();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
